// File: rtl/pit_pkg.sv
// Shared definitions for the 8254-style counter channel: mode encodings and
// half-period helpers. The helpers work on up to MAX_WIDTH-bit counts; a zero
// load value stands for 2^width.
package pit_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_INT_TC   = 2'b00;
  localparam mode_t MODE_RATE_GEN = 2'b01;
  localparam mode_t MODE_SQUARE   = 2'b10;

  localparam int MAX_WIDTH = 32;

  // Expand the 0-means-2^width encoding into an exact value one bit wider.
  function automatic logic [MAX_WIDTH:0] full_count(input logic [MAX_WIDTH-1:0] n,
                                                    input int width);
    logic [MAX_WIDTH:0] one;
    one = {{MAX_WIDTH{1'b0}}, 1'b1};
    return (n == '0) ? (one << width) : {1'b0, n};
  endfunction

  // High-phase length of a square wave: ceil(N/2).
  function automatic logic [MAX_WIDTH:0] half_ceil(input logic [MAX_WIDTH-1:0] n,
                                                   input int width);
    logic [MAX_WIDTH:0] full;
    full = full_count(n, width);
    return (full + 1'b1) >> 1;
  endfunction

  // Low-phase length of a square wave: floor(N/2).
  function automatic logic [MAX_WIDTH:0] half_floor(input logic [MAX_WIDTH-1:0] n,
                                                    input int width);
    logic [MAX_WIDTH:0] full;
    full = full_count(n, width);
    return full >> 1;
  endfunction

endpackage

// File: rtl/pit_count_latch.sv
// Count snapshot register with a valid/acknowledge handshake. A snapshot is
// taken only when none is held; an acknowledge releases it and takes priority
// over a simultaneous new request.
module pit_count_latch
  import pit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch_cmd,
  input  logic             read_ack,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] latched_count,
  output logic             latch_valid
);

  // Capture the live count on request and hold it until acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      latched_count <= '0;
      latch_valid   <= 1'b0;
    end else if (read_ack) begin
      latch_valid <= 1'b0;
    end else if (latch_cmd && !latch_valid) begin
      latched_count <= count;
      latch_valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/pit_counter_channel.sv
// One down-counter channel of an 8254-style timer: interrupt-on-terminal-count,
// rate-generator and square-wave modes, with gate control and a one-cycle
// terminal pulse. WIDTH must lie in 4..32.
// Optional feature: define COUNT_LATCH_EN to add the count snapshot latch
// (latch_cmd, read_ack, latched_count, latch_valid).
module pit_counter_channel
  import pit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [1:0]       mode,
  input  logic             gate,
`ifdef COUNT_LATCH_EN
  input  logic             latch_cmd,
  input  logic             read_ack,
  output logic [WIDTH-1:0] latched_count,
  output logic             latch_valid,
`endif
  output logic             out,
  output logic             terminal,
  output logic [WIDTH-1:0] count
);

  mode_t            mode_q;
  logic [WIDTH-1:0] reload;
  logic             armed;
  logic             gate_q;

  mode_t            mode_eff;
  logic [WIDTH-1:0] n_eff;
  logic [WIDTH-1:0] load_count;
  logic [WIDTH-1:0] rel_ceil;
  logic [WIDTH-1:0] rel_floor;
  logic             gate_rise;
  logic             at_one;

  // Decode the load request and the reload half-periods.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mode_eff   = (mode == 2'b11) ? MODE_INT_TC : mode_t'(mode);
    n_eff      = load_value;
    if (mode_eff != MODE_INT_TC && load_value == WIDTH'(1))
      n_eff = WIDTH'(2);
    load_count = n_eff;
    if (mode_eff == MODE_SQUARE)
      load_count = WIDTH'(half_ceil(MAX_WIDTH'(n_eff), WIDTH));
    rel_ceil   = WIDTH'(half_ceil(MAX_WIDTH'(reload), WIDTH));
    rel_floor  = WIDTH'(half_floor(MAX_WIDTH'(reload), WIDTH));
    gate_rise  = gate && !gate_q;
    at_one     = (count == WIDTH'(1));
  end

  // Track the previous gate level to detect a re-trigger.
  always_ff @(posedge clk) begin
    if (rst) gate_q <= 1'b0;
    else     gate_q <= gate;
  end

  // Counter datapath and mode sequencing; load beats gate and decrement.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      count    <= '0;
      reload   <= '0;
      mode_q   <= MODE_INT_TC;
      armed    <= 1'b0;
      out      <= 1'b0;
      terminal <= 1'b0;
    end else begin
      terminal <= 1'b0;
      if (load) begin
        reload <= n_eff;
        mode_q <= mode_eff;
        armed  <= 1'b1;
        count  <= load_count;
        out    <= (mode_eff != MODE_INT_TC);
      end else if (armed) begin
        case (mode_q)
          MODE_RATE_GEN: begin
            if (!gate) begin
              out <= 1'b1;
            end else if (gate_rise) begin
              count <= reload;
              out   <= 1'b1;
            end else if (at_one) begin
              count    <= reload;
              out      <= 1'b0;
              terminal <= 1'b1;
            end else begin
              count <= count - 1'b1;
              out   <= 1'b1;
            end
          end
          MODE_SQUARE: begin
            if (!gate) begin
              out <= 1'b1;
            end else if (gate_rise) begin
              count <= rel_ceil;
              out   <= 1'b1;
            end else if (at_one) begin
              if (out) begin
                count <= rel_floor;
                out   <= 1'b0;
              end else begin
                count    <= rel_ceil;
                out      <= 1'b1;
                terminal <= 1'b1;
              end
            end else begin
              count <= count - 1'b1;
            end
          end
          default: begin
            if (gate) begin
              if (at_one) begin
                count    <= '0;
                out      <= 1'b1;
                terminal <= 1'b1;
                armed    <= 1'b0;
              end else begin
                count <= count - 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

`ifdef COUNT_LATCH_EN
  pit_count_latch #(
    .WIDTH(WIDTH)
  ) u_latch (
    .clk          (clk),
    .rst          (rst),
    .latch_cmd    (latch_cmd),
    .read_ack     (read_ack),
    .count        (count),
    .latched_count(latched_count),
    .latch_valid  (latch_valid)
  );
`else
  // Without the snapshot latch, count is the only readback path.
`endif

endmodule
